// File: rtl/matrix_mult_arbiter.sv
// Round-robin front end that shares one matrix_mult unit between two requesters,
// holds operands for the whole operation and returns a tagged, held result.
module matrix_mult_arbiter #(
    parameter int unsigned MAT_W = 256,
    parameter int unsigned LAT   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [MAT_W-1:0] req0_m1,
    input  logic [MAT_W-1:0] req0_m2,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [MAT_W-1:0] req1_m1,
    input  logic [MAT_W-1:0] req1_m2,
    output logic             mm_enable,
    output logic [MAT_W-1:0] mm_m1,
    output logic [MAT_W-1:0] mm_m2,
    input  logic [MAT_W-1:0] mm_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [MAT_W-1:0] rsp_data,
    output logic             busy
);

    localparam int unsigned CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             last_gnt;
    logic             gnt_c;
    logic             accept_c;
    logic             capture_c;

    // Winner: the sole valid requester, or the one not granted last on a tie.
    always_comb begin
        gnt_c = req1_valid;
        if (req0_valid && req1_valid) begin
            gnt_c = ~last_gnt;
        end
    end

    assign req0_ready = (state == IDLE) && req0_valid && !gnt_c;
    assign req1_ready = (state == IDLE) && req1_valid && gnt_c;

    // Decoded straight from the state register so reset clears them at once.
    assign mm_enable = (state == ISSUE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        capture_c  = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept_c   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt == CNT_W'(LAT)) begin
                    capture_c  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands and response are only written on their strobes; mm_result is
    // never sampled outside the single capture edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mm_m1    <= '0;
            mm_m2    <= '0;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
            last_gnt <= 1'b1;
            cnt      <= '0;
        end else begin
            if (accept_c) begin
                mm_m1    <= gnt_c ? req1_m1 : req0_m1;
                mm_m2    <= gnt_c ? req1_m2 : req0_m2;
                rsp_id   <= gnt_c;
                last_gnt <= gnt_c;
                cnt      <= '0;
            end else if (state == ISSUE && !capture_c) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (capture_c) begin
                rsp_data <= mm_result;
            end
        end
    end

endmodule

// File: tb/tb_matrix_mult_arbiter.sv
// Directed bench for matrix_mult_arbiter with a behavioural LAT=1 matrix_mult
// that drives z whenever its enable is low.
module tb_matrix_mult_arbiter;

    localparam int unsigned MAT_W = 256;

    logic             clk;
    logic             reset;
    logic             req0_valid;
    logic             req0_ready;
    logic [MAT_W-1:0] req0_m1;
    logic [MAT_W-1:0] req0_m2;
    logic             req1_valid;
    logic             req1_ready;
    logic [MAT_W-1:0] req1_m1;
    logic [MAT_W-1:0] req1_m2;
    logic             mm_enable;
    logic [MAT_W-1:0] mm_m1;
    logic [MAT_W-1:0] mm_m2;
    logic [MAT_W-1:0] mm_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [MAT_W-1:0] rsp_data;
    logic             busy;

    int tests_run;
    int tests_failed;

    logic [MAT_W-1:0] ident;
    logic [MAT_W-1:0] seq_m;
    logic [MAT_W-1:0] a1_m;
    logic [MAT_W-1:0] all2;
    logic [MAT_W-1:0] all3;
    logic [MAT_W-1:0] all5;
    logic [MAT_W-1:0] all18;

    matrix_mult_arbiter #(.MAT_W(MAT_W), .LAT(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_m1    (req0_m1),
        .req0_m2    (req0_m2),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_m1    (req1_m1),
        .req1_m2    (req1_m2),
        .mm_enable  (mm_enable),
        .mm_m1      (mm_m1),
        .mm_m2      (mm_m2),
        .mm_result  (mm_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Element (r,c) of a 4x4 matrix sits at bits [16*(4r+c) +: 16].
    function automatic logic [MAT_W-1:0] mat_mul(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
        logic [MAT_W-1:0] r;
        logic [15:0]      s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 16'h0;
                for (int k = 0; k < 4; k++) begin
                    s = s + 16'(a[(i*4+k)*16 +: 16] * b[(k*4+j)*16 +: 16]);
                end
                r[(i*4+j)*16 +: 16] = s;
            end
        end
        return r;
    endfunction

    logic [MAT_W-1:0] mm_reg;
    always @(posedge clk) begin
        if (mm_enable) mm_reg <= mat_mul(mm_m1, mm_m2);
    end
    assign mm_result = mm_enable ? mm_reg : 'z;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output bit ok);
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        ok = rsp_valid;
    endtask

    task automatic clear_reqs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({mm_enable, rsp_valid, busy, rsp_id, req0_ready, req1_ready} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {mm_enable, rsp_valid, busy, rsp_id, req0_ready, req1_ready});
        end
        tests_run++;
        if (rsp_data !== '0 || mm_m1 !== '0 || mm_m2 !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: rsp_data=%h mm_m1=%h mm_m2=%h want 0", rsp_data, mm_m1, mm_m2);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_op();
        req0_m1 = ident;
        req0_m2 = seq_m;
        req0_valid = 1'b1;
        #1;
        tests_run++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_ready: r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        req0_m2 = '0;
        tests_run++;
        if (mm_enable !== 1'b1 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_issue: en=%b busy=%b rv=%b want 1 1 0", mm_enable, busy, rsp_valid);
        end
        tick();
        tests_run++;
        if (rsp_valid !== 1'b0 || mm_enable !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_lat1: rv=%b en=%b want 0 1", rsp_valid, mm_enable);
        end
        tick();
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== seq_m || mm_enable !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_rsp: rv=%b id=%b en=%b data=%h want 1 0 0 %h",
                     rsp_valid, rsp_id, mm_enable, rsp_data, seq_m);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done: busy=%b rv=%b want 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_alternate();
        bit ok;
        logic exp_id;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        req0_m1 = ident;
        req0_m2 = seq_m;
        req1_m1 = a1_m;
        req1_m2 = ident;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready = 1'b1;
        #1;
        for (int op = 0; op < 4; op++) begin
            exp_id = 1'(op % 2);
            tests_run++;
            if (req0_ready !== !exp_id || req1_ready !== exp_id) begin
                tests_failed++;
                $display("FAIL alt_grant%0d: r0=%b r1=%b want %b %b",
                         op, req0_ready, req1_ready, !exp_id, exp_id);
            end
            tick();
            wait_rsp(ok);
            tests_run++;
            if (!ok || rsp_id !== exp_id || rsp_data !== (exp_id ? a1_m : seq_m)) begin
                tests_failed++;
                $display("FAIL alt_rsp%0d: ok=%b id=%b data=%h want id %b data %h",
                         op, ok, rsp_id, rsp_data, exp_id, exp_id ? a1_m : seq_m);
            end
            tick();
        end
        clear_reqs();
    endtask

    task automatic test_backpressure();
        bit ok;
        rsp_ready = 1'b0;
        req1_m1 = a1_m;
        req1_m2 = ident;
        req1_valid = 1'b1;
        #1;
        tests_run++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_grant: r0=%b r1=%b want 0 1", req0_ready, req1_ready);
        end
        tick();
        req0_m1 = ident;
        req0_m2 = seq_m;
        req0_valid = 1'b1;
        wait_rsp(ok);
        for (int c = 0; c < 10; c++) begin
            tests_run++;
            if (!ok || rsp_valid !== 1'b1 || rsp_data !== a1_m || rsp_id !== 1'b1 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0 || mm_enable !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: rv=%b id=%b r0=%b r1=%b en=%b data=%h want 1 1 0 0 0 %h",
                         c, rsp_valid, rsp_id, req0_ready, req1_ready, mm_enable, rsp_data, a1_m);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        tests_run++;
        if (busy !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: busy=%b r0=%b r1=%b want 0 1 0", busy, req0_ready, req1_ready);
        end
        tick();
        clear_reqs();
        wait_rsp(ok);
        tests_run++;
        if (!ok || rsp_id !== 1'b0 || rsp_data !== seq_m) begin
            tests_failed++;
            $display("FAIL bp_next: ok=%b id=%b data=%h want id 0 data %h", ok, rsp_id, rsp_data, seq_m);
        end
        tick();
    endtask

    task automatic test_operand_stability();
        bit ok;
        rsp_ready = 1'b1;
        req0_m1 = all2;
        req0_m2 = all3;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        req0_m1 = all5;
        req0_m2 = '0;
        tests_run++;
        if (mm_m1 !== all2 || mm_m2 !== all3) begin
            tests_failed++;
            $display("FAIL stab_operands: mm_m1=%h mm_m2=%h want %h %h", mm_m1, mm_m2, all2, all3);
        end
        wait_rsp(ok);
        tests_run++;
        if (!ok || rsp_data !== all18 || rsp_id !== 1'b0) begin
            tests_failed++;
            $display("FAIL stab_result: ok=%b id=%b data=%h want %h", ok, rsp_id, rsp_data, all18);
        end
        tick();
    endtask

    task automatic test_reset_in_issue();
        bit ok;
        rsp_ready = 1'b1;
        req0_m1 = ident;
        req0_m2 = seq_m;
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (mm_enable !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_issue: en=%b busy=%b rv=%b want 0 0 0", mm_enable, busy, rsp_valid);
        end
        #1;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            tests_run++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_dropped%0d: rv=%b busy=%b want 0 0", c, rsp_valid, busy);
            end
        end
        req1_m1 = a1_m;
        req1_m2 = ident;
        req1_valid = 1'b1;
        #1;
        tests_run++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_after_grant: r0=%b r1=%b want 0 1", req0_ready, req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        wait_rsp(ok);
        tests_run++;
        if (!ok || rsp_id !== 1'b1 || rsp_data !== a1_m) begin
            tests_failed++;
            $display("FAIL rst_after_rsp: ok=%b id=%b data=%h want id 1 data %h", ok, rsp_id, rsp_data, a1_m);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run = 0;
        tests_failed = 0;
        ident = '0;
        seq_m = '0;
        a1_m  = '0;
        for (int k = 0; k < 16; k++) begin
            seq_m[k*16 +: 16] = 16'(k + 1);
            a1_m[k*16 +: 16]  = 16'(16'h0100 + k);
        end
        for (int d = 0; d < 4; d++) ident[(d*5)*16 +: 16] = 16'h0001;
        all2  = {16{16'h0002}};
        all3  = {16{16'h0003}};
        all5  = {16{16'h0005}};
        all18 = {16{16'h0018}};
        reset = 1'b0;
        rsp_ready = 1'b0;
        req0_m1 = '0;
        req0_m2 = '0;
        req1_m1 = '0;
        req1_m2 = '0;
        clear_reqs();

        test_reset();
        test_single_op();
        test_alternate();
        test_backpressure();
        test_operand_stability();
        test_reset_in_issue();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
